// File: rtl/uart_rx_frame_sampler.sv
// uart_rx_frame_sampler
//   Serial front end of the UART receiver. It synchronises the RX line and
//   finds a start bit. It then samples each bit of an LSB-first frame on the
//   oversampled baud tick. The frame is start, DATA_WIDTH data bits, an
//   optional parity bit and a stop bit. The sampled frame is handed on to
//   the error checker together with a one-clock recieved_flag.
//
//   Build option: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3
//   vote. The three samples are taken around the nominal sample point. When
//   the macro is undefined, a single sample is taken at the nominal point.
//
// Ports
//   clock          system clock
//   reset          asynchronous, active-high
//   baud_tick      one-clock enable at OVERSAMPLE x baud
//   data_tx        raw serial line, idle high, asynchronous
//   parity_type    01 odd, 10 even, 00/11 no parity bit in the frame
//   raw_data       received data, bit 0 = first data bit on the line
//   parity_bit     sampled parity bit (0 when the frame carries none)
//   start_bit      sampled start bit
//   stop_bit       sampled stop bit (0 = framing error / break)
//   recieved_flag  one-clock pulse when the frame outputs update
//   active_flag    high from START entry until IDLE re-entry
module uart_rx_frame_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  baud_tick,
    input  logic                  data_tx,
    input  logic [1:0]            parity_type,
    output logic [DATA_WIDTH-1:0] raw_data,
    output logic                  parity_bit,
    output logic                  start_bit,
    output logic                  stop_bit,
    output logic                  recieved_flag,
    output logic                  active_flag
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif
    // The start bit is decided LAG ticks past mid-bit. Its counter restart
    // then shifts the whole bit grid by LAG. Later bits therefore decide at
    // OVERSAMPLE-1 of the shifted grid, which is the M+1 position of the
    // original grid. This avoids any cumulative drift across the frame.
    localparam logic [CW-1:0] START_PT = CW'(OVERSAMPLE / 2 - 1 + LAG);
    localparam logic [CW-1:0] BIT_PT   = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t state, state_nx;

    logic [1:0]            sync_q;
    logic                  rx_s;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         samp_pt;
    logic                  samp_now;
    logic                  bit_val;
    logic [BW-1:0]         bit_idx;
    logic                  armed;
    logic [1:0]            ptype_q;
    logic                  has_par;
    logic [DATA_WIDTH-1:0] data_sh;
    logic                  par_sh;
    logic                  start_sh;
    logic                  start_det, start_ok, shift_en, par_en, stop_en;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], data_tx};
    end
    assign rx_s = sync_q[1];

    assign has_par  = (ptype_q == 2'b01) || (ptype_q == 2'b10);
    assign samp_pt  = (state == S_START) ? START_PT : BIT_PT;
    assign samp_now = baud_tick && (state != S_IDLE) && (cnt == samp_pt);

`ifdef UART_RX_MAJORITY_EN
    logic maj_a, maj_b;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            maj_a <= 1'b1;
            maj_b <= 1'b1;
        end else if (baud_tick) begin
            if (cnt == samp_pt - CW'(2)) maj_a <= rx_s;
            if (cnt == samp_pt - CW'(1)) maj_b <= rx_s;
        end
    end
    assign bit_val = (maj_a & maj_b) | (maj_a & rx_s) | (maj_b & rx_s);
`else
    assign bit_val = rx_s;
`endif

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // next state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (baud_tick && armed && !rx_s) state_nx = S_START;
            S_START:  if (samp_now) state_nx = bit_val ? S_IDLE : S_DATA;
            S_DATA:   if (samp_now && bit_idx == LAST_BIT)
                          state_nx = has_par ? S_PARITY : S_STOP;
            S_PARITY: if (samp_now) state_nx = S_STOP;
            S_STOP:   if (samp_now) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // outputs / datapath strobes
    always_comb begin
        active_flag = (state != S_IDLE);
        start_det   = (state == S_IDLE) && baud_tick && armed && !rx_s;
        start_ok    = (state == S_START) && samp_now && !bit_val;
        shift_en    = (state == S_DATA) && samp_now;
        par_en      = (state == S_PARITY) && samp_now;
        stop_en     = (state == S_STOP) && samp_now;
    end

    // The tick counter restarts on every state change and after each sample.
    // This keeps every bit period exactly OVERSAMPLE ticks long.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                               cnt <= '0;
        else if (state_nx != state || samp_now)  cnt <= '0;
        else if (baud_tick && state != S_IDLE)   cnt <= cnt + CW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed         <= 1'b0;
            ptype_q       <= 2'b00;
            bit_idx       <= '0;
            data_sh       <= '0;
            par_sh        <= 1'b0;
            start_sh      <= 1'b0;
            raw_data      <= '0;
            parity_bit    <= 1'b0;
            start_bit     <= 1'b0;
            stop_bit      <= 1'b1;
            recieved_flag <= 1'b0;
        end else begin
            recieved_flag <= stop_en;
            // Re-arming needs an idle-high line. A break held low after a
            // frame therefore cannot start a new frame.
            if (state == S_IDLE && baud_tick && rx_s) armed <= 1'b1;
            else if (stop_en)                         armed <= 1'b0;
            if (start_det) begin
                ptype_q <= parity_type;
                bit_idx <= '0;
                par_sh  <= 1'b0;
            end
            if (start_ok) start_sh <= bit_val;
            if (shift_en) begin
                data_sh <= {bit_val, data_sh[DATA_WIDTH-1:1]};
                bit_idx <= bit_idx + BW'(1);
            end
            if (par_en) par_sh <= bit_val;
            if (stop_en) begin
                raw_data   <= data_sh;
                parity_bit <= par_sh;
                start_bit  <= start_sh;
                stop_bit   <= bit_val;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_sampler.sv
// Testbench for uart_rx_frame_sampler. Frames are driven on a bit grid
// aligned to baud_tick. Expected outputs come from the frame contents
// actually placed on the line.
module tb_uart_rx_frame_sampler;
    localparam int OS   = 16;
    localparam int DW   = 8;
    localparam int TDIV = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          baud_tick = 1'b0;
    logic          data_tx = 1'b1;
    logic [1:0]    parity_type = 2'b00;
    logic [DW-1:0] raw_data;
    logic          parity_bit, start_bit, stop_bit, recieved_flag, active_flag;

    int n_chk = 0;
    int n_err = 0;
    int flag_cnt = 0;
    int tdiv = 0;
    logic [DW-1:0] cap_data = '0;
    logic          cap_par = 1'b0, cap_start = 1'b1, cap_stop = 1'b0;
    logic [DW-1:0] e_data = '0;
    logic          e_par = 1'b0, e_stop = 1'b1;

    uart_rx_frame_sampler #(.OVERSAMPLE(OS), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .baud_tick(baud_tick), .data_tx(data_tx),
        .parity_type(parity_type), .raw_data(raw_data), .parity_bit(parity_bit),
        .start_bit(start_bit), .stop_bit(stop_bit), .recieved_flag(recieved_flag),
        .active_flag(active_flag)
    );

    always #5 clock = ~clock;

    // Tick generation and flag capture, both away from the active edge.
    always @(negedge clock) begin
        baud_tick = (tdiv == 0);
        tdiv = (tdiv == TDIV - 1) ? 0 : tdiv + 1;
        if (recieved_flag) begin
            flag_cnt++;
            cap_data  = raw_data;
            cap_par   = parity_bit;
            cap_start = start_bit;
            cap_stop  = stop_bit;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Returns 1ns after the n-th clock edge that carries a baud_tick.
    task automatic tick_wait(input int n);
        repeat (n) begin
            do @(posedge clock); while (!baud_tick);
        end
        #1;
    endtask

    // One bit period. If gl >= 0, a one-tick low glitch is placed so that
    // the synchronised line is 0 only on tick gl+1 of the bit (the mid-bit).
    task automatic send_bit(input logic v, input int gl);
        data_tx = v;
        if (gl < 0) tick_wait(OS);
        else begin
            tick_wait(gl);
            data_tx = 1'b0;
            tick_wait(1);
            data_tx = v;
            tick_wait(OS - gl - 1);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_raw"},  raw_data,   e_data);
        chk({tag, "_par"},  parity_bit, e_par);
        chk({tag, "_stop"}, stop_bit,   e_stop);
    endtask

    // Drives a complete frame. parity_type is pt at the start bit and pt_mid
    // afterwards. The line is left at the stop-bit value.
    task automatic send_frame(input string tag, input logic [DW-1:0] d, input logic [1:0] pt,
                              input logic pb, input logic sb, input int glitch_bit,
                              input logic [1:0] pt_mid);
        int  f0;
        bit  with_par;
        logic [DW-1:0] exp_d;
        with_par = (pt == 2'b01) || (pt == 2'b10);
        parity_type = pt;
        data_tx = 1'b1;
        tick_wait(2);
        f0 = flag_cnt;
        send_bit(1'b0, -1);
        chk({tag, "_active"}, active_flag, 1'b1);
        parity_type = pt_mid;
        for (int i = 0; i < DW; i++) send_bit(d[i], (i == glitch_bit) ? OS / 2 : -1);
        if (with_par) send_bit(pb, -1);
        send_bit(sb, -1);
        exp_d = d;
`ifndef UART_RX_MAJORITY_EN
        if (glitch_bit >= 0) exp_d[glitch_bit] = 1'b0;
`endif
        e_data = exp_d;
        e_par  = with_par ? pb : 1'b0;
        e_stop = sb;
        chk({tag, "_flags"}, flag_cnt - f0, 1);
        chk({tag, "_cdata"}, cap_data, e_data);
        chk({tag, "_cpar"},  cap_par, e_par);
        chk({tag, "_cstart"}, cap_start, 1'b0);
        chk({tag, "_cstop"}, cap_stop, e_stop);
        check_outputs(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_raw"},   raw_data, '0);
        chk({tag, "_par"},   parity_bit, 1'b0);
        chk({tag, "_start"}, start_bit, 1'b0);
        chk({tag, "_stop"},  stop_bit, 1'b1);
        chk({tag, "_flag"},  recieved_flag, 1'b0);
        chk({tag, "_act"},   active_flag, 1'b0);
    endtask

    initial begin
        int f0;
        logic [DW-1:0] rd;
        logic [1:0] rpt, rptm;
        logic rpb, rsb;

        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("rst");
        reset = 1'b0;

        // 1: A5, even parity (bit 0), good stop
        send_frame("t1", 8'hA5, 2'b10, 1'b0, 1'b1, -1, 2'b10);

        // 2: 3C, no parity, stop low, line stays low for 40 more ticks
        f0 = flag_cnt;
        send_frame("t2", 8'h3C, 2'b00, 1'b0, 1'b0, -1, 2'b00);
        tick_wait(20);
        chk("t2_low_act", active_flag, 1'b0);
        tick_wait(20);
        chk("t2_low_flags", flag_cnt - f0, 1);
        data_tx = 1'b1;
        tick_wait(6);
        chk("t2_high_flags", flag_cnt - f0, 1);
        chk("t2_high_act", active_flag, 1'b0);

        // 3: false start, 4 ticks low
        f0 = flag_cnt;
        data_tx = 1'b0;
        tick_wait(4);
        data_tx = 1'b1;
        chk("t3_act_hi", active_flag, 1'b1);
        tick_wait(10);
        chk("t3_act_lo", active_flag, 1'b0);
        chk("t3_flags", flag_cnt - f0, 0);
        check_outputs("t3");

        // 4: reset after 3 data bits of 81, then 5A with odd parity bit 1
        f0 = flag_cnt;
        parity_type = 2'b00;
        data_tx = 1'b1;
        tick_wait(2);
        send_bit(1'b0, -1);
        send_bit(1'b1, -1);
        send_bit(1'b0, -1);
        send_bit(1'b0, -1);
        chk("t4_pre_act", active_flag, 1'b1);
        reset = 1'b1;
        data_tx = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("t4_rst");
        reset = 1'b0;
        chk("t4_rst_flags", flag_cnt - f0, 0);
        e_data = '0; e_par = 1'b0; e_stop = 1'b1;
        send_frame("t4", 8'h5A, 2'b01, 1'b1, 1'b1, -1, 2'b01);

        // 5: FF with a one-tick glitch on data bit 2
        send_frame("t5", 8'hFF, 2'b00, 1'b0, 1'b1, 2, 2'b00);

        // 6: parity type switched from odd to even after the start bit
        send_frame("t6", 8'h01, 2'b01, 1'b0, 1'b1, -1, 2'b10);

        // 6b: no-parity type latched, then switched to parity mid-frame
        send_frame("t6b", 8'hC3, 2'b11, 1'b0, 1'b1, -1, 2'b01);

        // randomized frames
        for (int k = 0; k < 16; k++) begin
            rd   = DW'($urandom);
            rpt  = 2'($urandom_range(0, 3));
            rptm = 2'($urandom_range(0, 3));
            rpb  = 1'($urandom_range(0, 1));
            rsb  = ($urandom_range(0, 3) != 0);
            send_frame("rnd", rd, rpt, rpb, rsb, -1, rptm);
        end
        data_tx = 1'b1;
        tick_wait(4);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
